conv_win_addr_gen: RTL and testbench
====================================

# conv_win_addr_gen

Parametrised convolution window address generator: for an image of up to `2^CH_W-1` channels stored channel-planar in a linear memory, it streams the memory address of every kernel tap of every output window under a valid/ready handshake. It adds configurable stride, multi-channel traversal, config validation and per-tap sideband flags. It sits between the layer controller (start/config) and the image RAM read port, feeding the MAC datapath in step.

## Interface
- `DIM_W`, 9, width of image/kernel dimensions and stride
- `ADDR_W`, 18, width of the linear memory address
- `CH_W`, 4, width of the channel count
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `img_w`, `img_h`  in  DIM_W  image width/height in pixels
- `ker_w`, `ker_h`  in  DIM_W  kernel width/height
- `stride`  in  DIM_W  window step in x and y
- `num_ch`  in  CH_W  channel count
- `addr`  out  ADDR_W  current tap address
- `addr_valid`  out  1  `addr` and sideband valid
- `addr_ready`  in  1  consumer accepts when high with `addr_valid`
- `tap_first`  out  1  first tap (kx=ky=0, ch=0) of a window
- `tap_last`  out  1  last tap (kx=ker_w-1, ky=ker_h-1, ch=num_ch-1) of a window
- `win_x`, `win_y`  out  DIM_W  output window index of current tap
- `busy`  out  1  high from PREP through DONE
- `done`  out  1  one-cycle pulse after final tap accepted
- `cfg_err`  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, PREP, RUN, DONE.
- IDLE: `start`=1 latches all config inputs. Config invalid if any of `ker_w`=0, `ker_h`=0, `stride`=0, `num_ch`=0, `ker_w>img_w`, `ker_h>img_h` -> pulse `cfg_err`, stay IDLE. Else -> PREP.
- PREP (1 cycle): compute `plane = img_w*img_h` (registered, ADDR_W bits), clear all counters/bases -> RUN.
- RUN: `addr = ch_base + row_base + col_base + kx`, where `row_base = (wy*stride+ky)*img_w`, `col_base = win_x*stride`, `ch_base = ch*plane`; all maintained incrementally by adders, no multiplier in RUN.
- Loop order, innermost first: kx (0..ker_w-1), ky (0..ker_h-1), ch (0..num_ch-1), win_x, win_y.
- win_x advances while `col_base+stride+ker_w <= img_w`, else wraps to 0 and win_y advances while `row_origin+stride+ker_h <= img_h`; no divider. Partial windows never emitted.
- Counters advance only on handshake (`addr_valid & addr_ready`). Final tap handshake -> DONE.
- DONE (1 cycle): `done`=1 -> IDLE.
- `start` in non-IDLE states ignored; config inputs may change freely after latch.
- Address arithmetic modulo 2^ADDR_W; caller sizes ADDR_W so `num_ch*plane` fits.

## Timing
- Reset values: `addr`=0, `addr_valid`=0, `tap_first`=0, `tap_last`=0, `win_x`=0, `win_y`=0, `busy`=0, `done`=0, `cfg_err`=0; state IDLE.
- `start` at edge N -> PREP in N+1 -> first `addr_valid` in N+2.
- `cfg_err` asserted the cycle after the rejected `start`.
- Throughput 1 tap/cycle with `addr_ready` held high; no bubbles at kx/ky/ch/window wraps.
- `addr_valid` stays high through RUN; `addr` and sideband held stable while `addr_valid & !addr_ready`.
- `done` one cycle after final handshake; `busy` falls with `done`; new `start` accepted the cycle after `done`.
- All outputs registered. Async `rst` mid-run: immediate return to reset values; no `done`.

## Structure
- Shared package `conv_pkg`: state encoding typedef, default DIM_W/ADDR_W/CH_W constants (shared with layer controller and MAC).
- One sub-module `win_step_ctr`: wrap-around counter with enable, terminal-count output; instantiated for kx, ky, ch, win_x, win_y.

## Test plan
- img 4x4, ker 3x3, stride 1, ch 1, ready=1 -> 36 taps; window (0,0) = 0,1,2,4,5,6,8,9,10; last tap 15 with `tap_last`; `done` 1 cycle after.
- img 5x5, ker 3x3, stride 2, ch 1 -> 4 windows; window (1,0) first addr 2; window (0,1) first addr 10; last addr 24.
- img 3x3, ker 2x2, stride 1, ch 2 -> window (0,0) = 0,1,3,4,9,10,12,13; `tap_first` on 0, `tap_last` on 13; 32 taps total.
- Random `addr_ready` backpressure on case 1 -> identical address sequence, outputs stable while stalled, 36 handshakes.
- `start` with ker_w=6 > img_w=4, and with stride=0 -> `cfg_err` pulse, `busy` stays 0, no `addr_valid`.
- `rst` asserted mid-RUN at tap 10 -> all outputs 0 immediately; fresh `start` reproduces sequence from addr 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the convolution address path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

   localparam int DEF_DIM_W  = 9;
   localparam int DEF_ADDR_W = 18;
   localparam int DEF_CH_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/win_step_ctr.sv
// Wrap-around loop counter with enable and terminal-count flag.
// Latency: count updates on the clock edge where en is high.
// Backpressure: holds its value whenever en is low.
module win_step_ctr #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] lim,
   input  logic         stop,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // terminal either by reaching the last index or by an external end condition
   assign tc  = (cnt_q == lim) | stop;
   assign cnt = cnt_q;

   // next count: clear dominates, otherwise step or wrap when enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + W'(1);
      end
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/conv_win_addr_gen.sv
// Streams the memory address of every kernel tap of every output window.
// Latency: start -> PREP next cycle -> first valid address the cycle after.
// Backpressure: addr and sideband hold while addr_valid & !addr_ready.
module conv_win_addr_gen
   import conv_pkg::*;
#(
   parameter int DIM_W  = DEF_DIM_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CH_W   = DEF_CH_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  img_w,
   input  logic [DIM_W-1:0]  img_h,
   input  logic [DIM_W-1:0]  ker_w,
   input  logic [DIM_W-1:0]  ker_h,
   input  logic [DIM_W-1:0]  stride,
   input  logic [CH_W-1:0]   num_ch,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic              tap_first,
   output logic              tap_last,
   output logic [DIM_W-1:0]  win_x,
   output logic [DIM_W-1:0]  win_y,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   state_t state_q, state_d;

   logic [DIM_W-1:0]  img_w_q, img_w_d, img_h_q, img_h_d;
   logic [DIM_W-1:0]  ker_w_q, ker_w_d, ker_h_q, ker_h_d;
   logic [DIM_W-1:0]  stride_q, stride_d;
   logic [CH_W-1:0]   num_ch_q, num_ch_d;

   logic [ADDR_W-1:0] plane_q, plane_d, row_step_q, row_step_d;
   logic [ADDR_W-1:0] win_row_q, win_row_d, ky_off_q, ky_off_d;
   logic [ADDR_W-1:0] ch_base_q, ch_base_d, addr_q, addr_d;
   logic [DIM_W-1:0]  col_base_q, col_base_d, row_pix_q, row_pix_d;

   logic addr_valid_q, addr_valid_d, tap_first_q, tap_first_d;
   logic tap_last_q, tap_last_d, busy_q, busy_d;
   logic done_q, done_d, cfg_err_q, cfg_err_d;

   logic [DIM_W-1:0] kx_cnt, ky_cnt, wx_cnt, wy_cnt;
   logic [CH_W-1:0]  ch_cnt;
   logic kx_tc, ky_tc, ch_tc, wx_tc, wy_tc;

   logic cfg_ok, clr, adv;
   logic kx_step, ky_step, ch_step, wx_step, wy_step, run_end;
   logic wx_end, wy_end;
   logic [DIM_W+1:0]   wx_reach, wy_reach;
   logic [2*DIM_W-1:0] plane_prod, step_prod;
   logic [DIM_W-1:0]   kx_n, ky_n;
   logic [CH_W-1:0]    ch_n;

   // config check on the live inputs at the start request
   assign cfg_ok = (ker_w != '0) && (ker_h != '0) && (stride != '0) &&
                   (num_ch != '0) && (ker_w <= img_w) && (ker_h <= img_h);

   // loop-carry chain: each level steps only when every inner level wraps
   assign clr     = (state_q == ST_PREP);
   assign adv     = (state_q == ST_RUN) & addr_valid_q & addr_ready;
   assign kx_step = adv;
   assign ky_step = kx_step & kx_tc;
   assign ch_step = ky_step & ky_tc;
   assign wx_step = ch_step & ch_tc;
   assign wy_step = wx_step & wx_tc;
   assign run_end = wy_step & wy_tc;

   // a further window fits only if origin+stride+kernel stays inside the image
   assign wx_reach = {2'b00, col_base_q} + {2'b00, stride_q} + {2'b00, ker_w_q};
   assign wy_reach = {2'b00, row_pix_q}  + {2'b00, stride_q} + {2'b00, ker_h_q};
   assign wx_end   = (wx_reach > {2'b00, img_w_q});
   assign wy_end   = (wy_reach > {2'b00, img_h_q});

   win_step_ctr #(.W(DIM_W)) u_kx (
      .clk(clk), .rst(rst), .clr(clr), .en(kx_step),
      .lim(ker_w_q - DIM_W'(1)), .stop(1'b0), .cnt(kx_cnt), .tc(kx_tc));
   win_step_ctr #(.W(DIM_W)) u_ky (
      .clk(clk), .rst(rst), .clr(clr), .en(ky_step),
      .lim(ker_h_q - DIM_W'(1)), .stop(1'b0), .cnt(ky_cnt), .tc(ky_tc));
   win_step_ctr #(.W(CH_W)) u_ch (
      .clk(clk), .rst(rst), .clr(clr), .en(ch_step),
      .lim(num_ch_q - CH_W'(1)), .stop(1'b0), .cnt(ch_cnt), .tc(ch_tc));
   win_step_ctr #(.W(DIM_W)) u_wx (
      .clk(clk), .rst(rst), .clr(clr), .en(wx_step),
      .lim({DIM_W{1'b1}}), .stop(wx_end), .cnt(wx_cnt), .tc(wx_tc));
   win_step_ctr #(.W(DIM_W)) u_wy (
      .clk(clk), .rst(rst), .clr(clr), .en(wy_step),
      .lim({DIM_W{1'b1}}), .stop(wy_end), .cnt(wy_cnt), .tc(wy_tc));

   // next-state and control outputs; config is captured only on an IDLE start
   always_comb begin
      state_d   = state_q;
      cfg_err_d = 1'b0;
      img_w_d   = img_w_q;
      img_h_d   = img_h_q;
      ker_w_d   = ker_w_q;
      ker_h_d   = ker_h_q;
      stride_d  = stride_q;
      num_ch_d  = num_ch_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               img_w_d  = img_w;
               img_h_d  = img_h;
               ker_w_d  = ker_w;
               ker_h_d  = ker_h;
               stride_d = stride;
               num_ch_d = num_ch;
               if (cfg_ok) state_d = ST_PREP;
               else        cfg_err_d = 1'b1;
            end
         end
         ST_PREP: state_d = ST_RUN;
         ST_RUN:  if (run_end) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      addr_valid_d = (state_d == ST_RUN);
   end

   // incremental bases; the only multiplies run once in PREP
   always_comb begin
      plane_prod = {{DIM_W{1'b0}}, img_w_q} * {{DIM_W{1'b0}}, img_h_q};
      step_prod  = {{DIM_W{1'b0}}, stride_q} * {{DIM_W{1'b0}}, img_w_q};
      plane_d    = plane_q;
      row_step_d = row_step_q;
      win_row_d  = win_row_q;
      ky_off_d   = ky_off_q;
      ch_base_d  = ch_base_q;
      col_base_d = col_base_q;
      row_pix_d  = row_pix_q;
      addr_d     = addr_q;
      tap_first_d = tap_first_q;
      tap_last_d  = tap_last_q;
      kx_n = kx_cnt;
      ky_n = ky_cnt;
      ch_n = ch_cnt;
      if (clr) begin
         plane_d    = ADDR_W'(plane_prod);
         row_step_d = ADDR_W'(step_prod);
         win_row_d  = '0;
         ky_off_d   = '0;
         ch_base_d  = '0;
         col_base_d = '0;
         row_pix_d  = '0;
         kx_n = '0;
         ky_n = '0;
         ch_n = '0;
      end else begin
         if (kx_step) kx_n = kx_tc ? '0 : kx_cnt + DIM_W'(1);
         if (ky_step) begin
            ky_n     = ky_tc ? '0 : ky_cnt + DIM_W'(1);
            ky_off_d = ky_tc ? '0 : ky_off_q + ADDR_W'(img_w_q);
         end
         if (ch_step) begin
            ch_n      = ch_tc ? '0 : ch_cnt + CH_W'(1);
            ch_base_d = ch_tc ? '0 : ch_base_q + plane_q;
         end
         if (wx_step) col_base_d = wx_tc ? '0 : col_base_q + stride_q;
         if (wy_step) begin
            row_pix_d = wy_tc ? '0 : row_pix_q + stride_q;
            win_row_d = wy_tc ? '0 : win_row_q + row_step_q;
         end
      end
      if (clr || adv) begin
         addr_d = ch_base_d + win_row_d + ky_off_d + ADDR_W'(col_base_d) + ADDR_W'(kx_n);
         tap_first_d = addr_valid_d && (kx_n == '0) && (ky_n == '0) && (ch_n == '0);
         tap_last_d  = addr_valid_d && (kx_n == ker_w_q - DIM_W'(1)) &&
                       (ky_n == ker_h_q - DIM_W'(1)) && (ch_n == num_ch_q - CH_W'(1));
      end
   end

   // state, config and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         img_w_q      <= '0;
         img_h_q      <= '0;
         ker_w_q      <= '0;
         ker_h_q      <= '0;
         stride_q     <= '0;
         num_ch_q     <= '0;
         plane_q      <= '0;
         row_step_q   <= '0;
         win_row_q    <= '0;
         ky_off_q     <= '0;
         ch_base_q    <= '0;
         col_base_q   <= '0;
         row_pix_q    <= '0;
         addr_q       <= '0;
         addr_valid_q <= 1'b0;
         tap_first_q  <= 1'b0;
         tap_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         img_w_q      <= img_w_d;
         img_h_q      <= img_h_d;
         ker_w_q      <= ker_w_d;
         ker_h_q      <= ker_h_d;
         stride_q     <= stride_d;
         num_ch_q     <= num_ch_d;
         plane_q      <= plane_d;
         row_step_q   <= row_step_d;
         win_row_q    <= win_row_d;
         ky_off_q     <= ky_off_d;
         ch_base_q    <= ch_base_d;
         col_base_q   <= col_base_d;
         row_pix_q    <= row_pix_d;
         addr_q       <= addr_d;
         addr_valid_q <= addr_valid_d;
         tap_first_q  <= tap_first_d;
         tap_last_q   <= tap_last_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign addr       = addr_q;
   assign addr_valid = addr_valid_q;
   assign tap_first  = tap_first_q;
   assign tap_last   = tap_last_q;
   assign win_x      = wx_cnt;
   assign win_y      = wy_cnt;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_conv_win_addr_gen.sv
// Directed bench for conv_win_addr_gen with a queue-based tap scoreboard.
// Latency: checks start->PREP->first valid and done one cycle after last tap.
// Backpressure: optional random addr_ready with output-hold checks.
module tb_conv_win_addr_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  img_w = '0, img_h = '0, ker_w = '0, ker_h = '0, stride = '0;
   logic [3:0]  num_ch = '0;
   logic [17:0] addr;
   logic        addr_valid, addr_ready, tap_first, tap_last, busy, done, cfg_err;
   logic [8:0]  win_x, win_y;

   typedef struct packed {
      logic [17:0] addr;
      logic        first;
      logic        last;
      logic [8:0]  wx;
      logic [8:0]  wy;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int hs_cnt;
   logic [17:0] last_addr;

   always #5 clk = ~clk;

   conv_win_addr_gen dut (
      .clk(clk), .rst(rst), .start(start),
      .img_w(img_w), .img_h(img_h), .ker_w(ker_w), .ker_h(ker_h),
      .stride(stride), .num_ch(num_ch),
      .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
      .tap_first(tap_first), .tap_last(tap_last),
      .win_x(win_x), .win_y(win_y),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference traversal written as plain nested loops
   task automatic gen_exp(input int iw, input int ih, input int kw, input int kh,
                          input int s, input int nc);
      exp_t e;
      sb.delete();
      for (int wy = 0; wy * s + kh <= ih; wy++)
         for (int wx = 0; wx * s + kw <= iw; wx++)
            for (int c = 0; c < nc; c++)
               for (int ky = 0; ky < kh; ky++)
                  for (int kx = 0; kx < kw; kx++) begin
                     e.addr  = 18'(c * iw * ih + (wy * s + ky) * iw + wx * s + kx);
                     e.first = (kx == 0) && (ky == 0) && (c == 0);
                     e.last  = (kx == kw - 1) && (ky == kh - 1) && (c == nc - 1);
                     e.wx    = 9'(wx);
                     e.wy    = 9'(wy);
                     sb.push_back(e);
                  end
   endtask

   task automatic run_case(input int iw, input int ih, input int kw, input int kh,
                           input int s, input int nc, input bit rnd, input int stop_at);
      int n, lim, cyc;
      bit stalled;
      exp_t e, held, cur;
      gen_exp(iw, ih, kw, kh, s, nc);
      n   = sb.size();
      lim = (stop_at > 0) ? stop_at : n;
      @(negedge clk);
      img_w = 9'(iw); img_h = 9'(ih); ker_w = 9'(kw); ker_h = 9'(kh);
      stride = 9'(s); num_ch = 4'(nc); start = 1'b1; addr_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      img_w = 9'd1; img_h = 9'd1; ker_w = 9'd0; stride = 9'd0; num_ch = 4'd0;
      chk("prep_busy", 32'(busy), 32'd1);
      chk("prep_vld", 32'(addr_valid), 32'd0);
      @(negedge clk);
      chk("first_vld", 32'(addr_valid), 32'd1);
      hs_cnt = 0; cyc = 0; stalled = 1'b0; held = '0;
      while (hs_cnt < lim && cyc < 4000) begin
         cur = '{addr, tap_first, tap_last, win_x, win_y};
         if (stalled) chk("hold", 32'(cur ^ held), 32'd0);
         addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (addr_valid && addr_ready) begin
            e = sb.pop_front();
            chk("addr", 32'(addr), 32'(e.addr));
            chk("side", {12'd0, tap_first, tap_last, win_x, win_y},
                {12'd0, e.first, e.last, e.wx, e.wy});
            last_addr = addr;
            hs_cnt++;
         end else if (!addr_valid) begin
            chk("vld_drop", 32'(addr_valid), 32'd1);
         end
         stalled = addr_valid && !addr_ready;
         held = cur;
         cyc++;
         @(negedge clk);
      end
      chk("hs_count", 32'(hs_cnt), 32'(lim));
      if (stop_at == 0) begin
         if (!rnd) chk("throughput", 32'(cyc), 32'(n));
         chk("done_pulse", {busy, done, addr_valid}, 32'b110);
         @(negedge clk);
         chk("after_done", {busy, done, addr_valid}, 32'b000);
      end
   endtask

   task automatic bad_cfg(input int iw, input int kw, input int s);
      @(negedge clk);
      img_w = 9'(iw); img_h = 9'd4; ker_w = 9'(kw); ker_h = 9'd3;
      stride = 9'(s); num_ch = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("cfg_err_pulse", {cfg_err, busy, addr_valid}, 32'b100);
      @(negedge clk);
      chk("cfg_err_clear", {cfg_err, busy, addr_valid}, 32'b000);
      @(negedge clk);
      chk("cfg_err_idle", {cfg_err, busy, addr_valid}, 32'b000);
   endtask

   initial begin
      addr_ready = 1'b1;
      @(negedge clk);
      chk("rst_outs", {addr, addr_valid, tap_first, tap_last, busy, done, cfg_err}, 32'd0);
      chk("rst_win", {win_x, win_y}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 4x4 image, 3x3 kernel, stride 1, one channel
      run_case(4, 4, 3, 3, 1, 1, 1'b0, 0);
      chk("c1_taps", 32'(hs_cnt), 32'd36);
      chk("c1_last", 32'(last_addr), 32'd15);

      // 5x5 image, 3x3 kernel, stride 2
      run_case(5, 5, 3, 3, 2, 1, 1'b0, 0);
      chk("c2_taps", 32'(hs_cnt), 32'd36);
      chk("c2_last", 32'(last_addr), 32'd24);

      // 3x3 image, 2x2 kernel, two channels
      run_case(3, 3, 2, 2, 1, 2, 1'b0, 0);
      chk("c3_taps", 32'(hs_cnt), 32'd32);
      chk("c3_last", 32'(last_addr), 32'd17);

      // random backpressure on the first case
      run_case(4, 4, 3, 3, 1, 1, 1'b1, 0);
      chk("bp_taps", 32'(hs_cnt), 32'd36);

      // rejected configurations
      bad_cfg(4, 6, 1);
      bad_cfg(4, 3, 0);

      // asynchronous reset after ten taps
      run_case(4, 4, 3, 3, 1, 1, 1'b0, 10);
      #2 rst = 1'b1;
      #1;
      chk("midrst_outs", {addr, addr_valid, tap_first, tap_last, busy, done, cfg_err}, 32'd0);
      chk("midrst_win", {win_x, win_y}, 32'd0);
      @(negedge clk);
      chk("midrst_nodone", {busy, done}, 32'd0);
      rst = 1'b0;
      run_case(4, 4, 3, 3, 1, 1, 1'b0, 0);
      chk("rerun_taps", 32'(hs_cnt), 32'd36);
      chk("rerun_last", 32'(last_addr), 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
